// File: rtl/csit_luks_encoder.sv
// Rotary quadrature encoder (x4 decode) with an 8-bit position counter and a
// debounced active-low pushbutton that captures the count into a hold register.
module csit_luks_encoder #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic {
        BTN_RELEASED = 1'b0,
        BTN_PRESSED  = 1'b1
    } btn_state_e;

    logic [SYNC_STAGES-1:0] a_sync_q;
    logic [SYNC_STAGES-1:0] b_sync_q;
    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic [1:0]             prev_ab_q;
    logic [1:0]             cur_ab;
    logic [7:0]             count_q, count_d;
    logic [7:0]             hold_q, hold_d;
    logic [DW-1:0]          db_cnt_q, db_cnt_d;
    btn_state_e             btn_state_q, btn_state_d;
    logic                   btn_low;
    logic                   press_pulse;
    logic                   unused_ok;

    assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};

    assign cur_ab  = {b_sync_q[SYNC_STAGES-1], a_sync_q[SYNC_STAGES-1]};
    assign btn_low = ~btn_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sync_q    <= '0;
            b_sync_q    <= '0;
            btn_sync_q  <= '1;
            prev_ab_q   <= '0;
            count_q     <= '0;
            hold_q      <= '0;
            db_cnt_q    <= '0;
            btn_state_q <= BTN_RELEASED;
        end else begin
            a_sync_q    <= {a_sync_q[SYNC_STAGES-2:0], ui_in[0]};
            b_sync_q    <= {b_sync_q[SYNC_STAGES-2:0], ui_in[1]};
            btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], ui_in[2]};
            prev_ab_q   <= cur_ab;
            count_q     <= count_d;
            hold_q      <= hold_d;
            db_cnt_q    <= db_cnt_d;
            btn_state_q <= btn_state_d;
        end
    end

    // Gray-code step decode: single-bit changes only; double-bit jumps are ignored.
    always_comb begin
        count_d = count_q;
        unique case ({prev_ab_q, cur_ab})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: count_d = count_q + 8'd1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: count_d = count_q - 8'd1;
            default:                                count_d = count_q;
        endcase
    end

    always_comb begin
        btn_state_d = btn_state_q;
        db_cnt_d    = '0;
        press_pulse = 1'b0;
        if ((btn_state_q == BTN_PRESSED) != btn_low) begin
            if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                btn_state_d = (btn_state_q == BTN_PRESSED) ? BTN_RELEASED : BTN_PRESSED;
                press_pulse = (btn_state_q == BTN_RELEASED);
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end
    end

    // Capture uses count_q, so a simultaneous encoder step is not included.
    always_comb begin
        hold_d = hold_q;
        if (press_pulse) begin
            hold_d = count_q;
        end
    end

    assign uo_out  = count_q;
    assign uio_out = hold_q;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_csit_luks_encoder.sv
// Randomized and directed bench for csit_luks_encoder against a behavioural model.
module tb_csit_luks_encoder;

    localparam int SYNC = 2;
    localparam int DEB  = 16;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [2:0] m_pipe[$];
    logic [1:0] m_prev;
    int         m_cnt;
    int         m_hold;
    int         m_run;
    bit         m_pressed;

    csit_luks_encoder #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int gray_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        m_pipe.delete();
        for (int i = 0; i < SYNC; i++) m_pipe.push_back(3'b100);
        m_prev    = 2'b00;
        m_cnt     = 0;
        m_hold    = 0;
        m_run     = 0;
        m_pressed = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] pins);
        logic [2:0] syn;
        int         step;
        int         cnt_old;
        syn = m_pipe.pop_front();
        m_pipe.push_back(pins);
        cnt_old = m_cnt;
        step = (gray_pos(syn[1:0]) - gray_pos(m_prev) + 4) % 4;
        if (step == 1) m_cnt = (m_cnt + 1) % 256;
        else if (step == 3) m_cnt = (m_cnt + 255) % 256;
        m_prev = syn[1:0];
        if ((syn[2] == 1'b0) != m_pressed) m_run++;
        else m_run = 0;
        if (m_run == DEB) begin
            if (!m_pressed) m_hold = cnt_old;
            m_pressed = !m_pressed;
            m_run = 0;
        end
    endtask

    // One clock: drive, model the edge, compare at the falling edge.
    task automatic tick(input logic [7:0] ui, input logic r);
        ui_in = ui;
        rst   = r;
        @(posedge clk);
        if (r) model_reset();
        else model_step(ui[2:0]);
        @(negedge clk);
        check_val("uo_out", uo_out, 8'(m_cnt));
        check_val("uio_out", uio_out, 8'(m_hold));
    endtask

    task automatic drive_ab(input logic [1:0] ab, input logic btn);
        tick({5'b0, btn, ab}, 1'b0);
    endtask

    task automatic idle(input int n, input logic [1:0] ab, input logic btn);
        for (int i = 0; i < n; i++) drive_ab(ab, btn);
    endtask

    logic [1:0] cw_seq[10]  = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    logic [1:0] ccw_pat[4]  = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] cw_to255[7] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01};

    initial begin
        logic       btn;
        logic [1:0] ab;
        ena    = 1'b1;
        uio_in = 8'h00;
        ui_in  = 8'b0000_0100;
        rst    = 1'b1;
        model_reset();

        for (int i = 0; i < 10; i++) tick(8'b0000_0100, 1'b1);
        check_val("reset uo_out", uo_out, 8'd0);
        check_val("reset uio_out", uio_out, 8'd0);
        check_val("reset uio_oe", uio_oe, 8'hFF);

        foreach (cw_seq[i]) drive_ab(cw_seq[i], 1'b1);
        idle(SYNC + 2, 2'b01, 1'b1);
        check_val("cw run", uo_out, 8'd9);

        idle(50, 2'b01, 1'b0);
        check_val("press hold", uio_out, 8'd9);
        check_val("press count", uo_out, 8'd9);
        idle(30, 2'b01, 1'b1);
        check_val("release hold", uio_out, 8'd9);

        for (int i = 0; i < 18; i++) drive_ab(ccw_pat[i % 4], 1'b1);
        idle(SYNC + 2, 2'b10, 1'b1);
        check_val("ccw wrap", uo_out, 8'd247);

        idle(100, 2'b10, 1'b0);
        check_val("second press", uio_out, 8'd247);
        idle(30, 2'b10, 1'b1);

        idle(5, 2'b10, 1'b0);
        idle(30, 2'b10, 1'b1);
        check_val("glitch press", uio_out, 8'd247);
        check_val("uio_oe run", uio_oe, 8'hFF);

        idle(SYNC + 2, 2'b00, 1'b1);
        check_val("step to 00", uo_out, 8'd248);
        idle(SYNC + 2, 2'b11, 1'b1);
        check_val("illegal jump", uo_out, 8'd248);

        foreach (cw_to255[i]) drive_ab(cw_to255[i], 1'b1);
        idle(SYNC + 2, 2'b01, 1'b1);
        check_val("at 255", uo_out, 8'd255);
        idle(SYNC + 2, 2'b11, 1'b1);
        check_val("wrap to 0", uo_out, 8'd0);

        btn = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) btn = ~btn;
            ab = 2'($urandom_range(0, 3));
            if (i >= 300 && i < 303) begin
                tick({5'b0, btn, ab}, 1'b1);
                check_val("mid reset uio_oe", uio_oe, 8'hFF);
            end else begin
                drive_ab(ab, btn);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
